// File: rtl/output_accum_ctrl_if.sv
// Partial-sum lanes and dual-port output-memory bus of the accumulate controller.
interface output_accum_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 512
);
  logic              psum_1_valid;
  logic              psum_1_ready;
  logic [ADDR_W-1:0] psum_1_addr;
  logic              psum_1_first;
  logic [DATA_W-1:0] psum_1_data;
  logic              psum_2_valid;
  logic              psum_2_ready;
  logic [ADDR_W-1:0] psum_2_addr;
  logic              psum_2_first;
  logic [DATA_W-1:0] psum_2_data;
  logic              mem_rd_1_valid;
  logic [ADDR_W-1:0] mem_rd_1_addr;
  logic              mem_rd_2_valid;
  logic [ADDR_W-1:0] mem_rd_2_addr;
  logic [DATA_W-1:0] mem_rdata_1;
  logic [DATA_W-1:0] mem_rdata_2;
  logic              mem_wr_1_valid;
  logic [ADDR_W-1:0] mem_wr_1_addr;
  logic [DATA_W-1:0] mem_wr_1_data;
  logic              mem_wr_2_valid;
  logic [ADDR_W-1:0] mem_wr_2_addr;
  logic [DATA_W-1:0] mem_wr_2_data;

  // Producer side: PE output stage plus the memory it talks to.
  modport master (
    output psum_1_valid, psum_1_addr, psum_1_first, psum_1_data,
    output psum_2_valid, psum_2_addr, psum_2_first, psum_2_data,
    input  psum_1_ready, psum_2_ready,
    input  mem_rd_1_valid, mem_rd_1_addr, mem_rd_2_valid, mem_rd_2_addr,
    output mem_rdata_1, mem_rdata_2,
    input  mem_wr_1_valid, mem_wr_1_addr, mem_wr_1_data,
    input  mem_wr_2_valid, mem_wr_2_addr, mem_wr_2_data
  );

  // Controller side.
  modport slave (
    input  psum_1_valid, psum_1_addr, psum_1_first, psum_1_data,
    input  psum_2_valid, psum_2_addr, psum_2_first, psum_2_data,
    output psum_1_ready, psum_2_ready,
    output mem_rd_1_valid, mem_rd_1_addr, mem_rd_2_valid, mem_rd_2_addr,
    input  mem_rdata_1, mem_rdata_2,
    output mem_wr_1_valid, mem_wr_1_addr, mem_wr_1_data,
    output mem_wr_2_valid, mem_wr_2_addr, mem_wr_2_data
  );
endinterface

// File: rtl/output_accum_ctrl.sv
// Two-lane read-modify-write accumulator in front of the dual-port output memory.
// Read issues in the accept cycle, write-back follows one cycle later; the
// previous cycle's writes are forwarded because memory reads do not see them.
module output_accum_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 512,
  parameter int unsigned LANE_W   = 32,
  parameter int unsigned SATURATE = 0
) (
  input  logic                clk,
  input  logic                reset,
  output_accum_ctrl_if.slave  bus,
  output logic                busy,
  output logic [15:0]         wr_count
);
  localparam int unsigned NUM_EL = DATA_W / LANE_W;

  logic [1:0]        w_in_vld, w_in_first, w_acc, w_rd_vld, w_wr_vld;
  logic [ADDR_W-1:0] w_in_addr [2];
  logic [DATA_W-1:0] w_in_data [2];
  logic [DATA_W-1:0] w_rdata   [2];
  logic [DATA_W-1:0] w_old     [2];
  logic [DATA_W-1:0] w_sum     [2];
  logic              w_collide;

  logic [1:0]        r_vld, r_first, r_pw_vld;
  logic [ADDR_W-1:0] r_addr    [2];
  logic [DATA_W-1:0] r_data    [2];
  logic [ADDR_W-1:0] r_pw_addr [2];
  logic [DATA_W-1:0] r_pw_data [2];
  logic [15:0]       r_wr_count;

  // Element-wise add, wrapping or signed-saturating per element.
  function automatic logic [DATA_W-1:0] f_accum(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] res;
    logic [LANE_W-1:0] ea, eb;
    logic [LANE_W:0]   ext;
    res = '0;
    for (int i = 0; i < int'(NUM_EL); i++) begin
      ea  = a[i*LANE_W +: LANE_W];
      eb  = b[i*LANE_W +: LANE_W];
      ext = {ea[LANE_W-1], ea} + {eb[LANE_W-1], eb};
      if ((SATURATE != 0) && (ext[LANE_W] != ext[LANE_W-1]))
        res[i*LANE_W +: LANE_W] = ext[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                              : {1'b0, {(LANE_W-1){1'b1}}};
      else
        res[i*LANE_W +: LANE_W] = ext[LANE_W-1:0];
    end
    return res;
  endfunction

  // Lane-1 priority; lane 2 waits one cycle on a same-address collision.
  assign w_collide        = bus.psum_1_valid && bus.psum_2_valid &&
                            (bus.psum_1_addr == bus.psum_2_addr);
  assign bus.psum_1_ready = 1'b1;
  assign bus.psum_2_ready = ~w_collide;

  // Accept, read request, forwarding select and write-back sum per lane.
  always_comb begin
    w_in_vld     = {bus.psum_2_valid, bus.psum_1_valid};
    w_in_first   = {bus.psum_2_first, bus.psum_1_first};
    w_in_addr[0] = bus.psum_1_addr;
    w_in_addr[1] = bus.psum_2_addr;
    w_in_data[0] = bus.psum_1_data;
    w_in_data[1] = bus.psum_2_data;
    w_rdata[0]   = bus.mem_rdata_1;
    w_rdata[1]   = bus.mem_rdata_2;
    w_acc        = {w_in_vld[1] & ~w_collide, w_in_vld[0]};
    w_rd_vld     = w_acc & ~w_in_first & {2{~reset}};
    w_wr_vld     = r_vld & {2{~reset}};
    for (int l = 0; l < 2; l++) begin
      if (r_pw_vld[0] && (r_pw_addr[0] == r_addr[l]))
        w_old[l] = r_pw_data[0];
      else if (r_pw_vld[1] && (r_pw_addr[1] == r_addr[l]))
        w_old[l] = r_pw_data[1];
      else
        w_old[l] = w_rdata[l];
      w_sum[l] = r_first[l] ? r_data[l] : f_accum(w_old[l], r_data[l]);
    end
  end

  // Memory port drive; address/data held at zero while idle.
  always_comb begin
    bus.mem_rd_1_valid = w_rd_vld[0];
    bus.mem_rd_1_addr  = w_rd_vld[0] ? w_in_addr[0] : '0;
    bus.mem_rd_2_valid = w_rd_vld[1];
    bus.mem_rd_2_addr  = w_rd_vld[1] ? w_in_addr[1] : '0;
    bus.mem_wr_1_valid = w_wr_vld[0];
    bus.mem_wr_1_addr  = w_wr_vld[0] ? r_addr[0] : '0;
    bus.mem_wr_1_data  = w_wr_vld[0] ? w_sum[0] : '0;
    bus.mem_wr_2_valid = w_wr_vld[1];
    bus.mem_wr_2_addr  = w_wr_vld[1] ? r_addr[1] : '0;
    bus.mem_wr_2_data  = w_wr_vld[1] ? w_sum[1] : '0;
  end

  // Stage register, last-write forwarding copy and write counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld      <= '0;
      r_first    <= '0;
      r_pw_vld   <= '0;
      r_wr_count <= '0;
      for (int l = 0; l < 2; l++) begin
        r_addr[l]    <= '0;
        r_data[l]    <= '0;
        r_pw_addr[l] <= '0;
        r_pw_data[l] <= '0;
      end
    end else begin
      r_vld      <= w_acc;
      r_pw_vld   <= w_wr_vld;
      r_wr_count <= r_wr_count + 16'(w_wr_vld[0]) + 16'(w_wr_vld[1]);
      for (int l = 0; l < 2; l++) begin
        if (w_acc[l]) begin
          r_addr[l]  <= w_in_addr[l];
          r_data[l]  <= w_in_data[l];
          r_first[l] <= w_in_first[l];
        end
        r_pw_addr[l] <= r_addr[l];
        r_pw_data[l] <= w_sum[l];
      end
    end
  end

  assign busy     = |r_vld;
  assign wr_count = r_wr_count;
endmodule
